serial_frame_tx: RTL

- Parallel-to-serial frame transmitter that feeds the 4-bit serial-in shift register stage (drives its Din).
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word one bit at a time on Dout, with per-bit strobes and frame markers.
- Supports a programmable bit period and a programmable inter-frame gap, so downstream shift/compare stages see a well-defined bit stream.

---
 rtl/serial_frame_tx_if.sv | 21 ++
 rtl/serial_frame_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx_if.sv
// Load-side valid/ready handshake of serial_frame_tx.
// The producer uses the master modport; the transmitter uses the slave modport.
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter with programmable bit period and inter-frame gap.
// The serial outputs are decoded from registered state, so Dout is glitch-free per bit period.
module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int BIT_DIV   = 1,
  parameter int GAP       = 0
) (
  input  logic                clk,
  input  logic                clr,
  serial_frame_tx_if.slave    load,
  output logic                Dout,
  output logic                bit_valid,
  output logic                first_bit,
  output logic                last_bit,
  output logic                busy
);

  localparam int BW      = $clog2(WIDTH);
  localparam int DW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GAP_CYC = GAP * BIT_DIV;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam bit CHAIN   = (GAP == 0);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;

  logic             tx_bit;
  logic [WIDTH-1:0] shreg_shifted;
  logic             in_shift;
  logic             frame_end;
  logic             ready;
  logic             accept;

  // The outgoing bit always sits at one end of the holding register.
  generate
    if (MSB_FIRST) begin : g_msb
      assign tx_bit        = shreg_q[WIDTH-1];
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign tx_bit        = shreg_q[0];
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign in_shift  = (state_q == ST_SHIFT);
  assign frame_end = in_shift && (div_cnt_q == DIV_LAST) && (bit_cnt_q == BIT_LAST);

  // Without a gap, the final cycle of a frame can take the next word for back-to-back frames.
  assign ready  = (state_q == ST_IDLE) || (CHAIN && frame_end);
  assign accept = ready && load.load_valid;
  assign load.load_ready = ready;

  assign Dout      = in_shift && tx_bit;
  assign bit_valid = in_shift && (div_cnt_q == '0);
  assign first_bit = bit_valid && (bit_cnt_q == '0);
  assign last_bit  = bit_valid && (bit_cnt_q == BIT_LAST);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d   = load.load_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (accept) begin
              shreg_d = load.load_data;
              state_d = ST_SHIFT;
            end else if (CHAIN) begin
              state_d = ST_IDLE;
            end else begin
              gap_cnt_d = '0;
              state_d   = ST_GAP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_shifted;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule
